// File: rtl/bk_sub_pkg.sv
// Shared constants for the pipelined Brent-Kung subtractor: default width,
// pipeline depth and the index of each stage inside the valid vector.
package bk_sub_pkg;

    localparam int BK_W_DEFAULT = 32;
    localparam int BK_LATENCY   = 3;

    localparam int BK_STG_S1 = 0;
    localparam int BK_STG_S2 = 1;
    localparam int BK_STG_S3 = 2;

    // Number of prefix-tree levels for a power-of-two width.
    function automatic int bk_log2(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < w) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_pg_merge.sv
// Brent-Kung prefix cell: merges a higher group (hi) with the adjacent lower
// group (lo) into one generate/propagate pair.
module bk_pg_merge
    import bk_sub_pkg::*;
(
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/bk_sub32_pipe.sv
// Three-stage pipelined subtractor d = a - b - bin built on a Brent-Kung prefix
// network (a + ~b + ~bin). Define BK_SUB_OVF_EN to add the signed-overflow port.
module bk_sub32_pipe
    import bk_sub_pkg::*;
#(
    parameter int W = BK_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bout
`ifdef BK_SUB_OVF_EN
   ,output logic         ovf
`endif
);

    localparam int LOG = bk_log2(W);

    logic [BK_LATENCY-1:0] valid_reg;
    logic                  advance;

    logic [W-1:0] s1_p_reg, s1_g_reg;
    logic         s1_cin_reg;
    logic [W-1:0] s2_g_reg, s2_p_reg, s2_pbit_reg;
    logic         s2_cin_reg;
    logic [W-1:0] d_reg;
    logic         bout_reg;

    logic [W-1:0] g0_fold;
    logic [W-1:0] up_g, up_p;
    logic [W-1:0] carry_vec;
    logic [W-1:0] d_next;
    logic         bout_next;

`ifdef BK_SUB_OVF_EN
    logic s1_sa_reg, s1_sb_reg;
    logic s2_sa_reg, s2_sb_reg;
    logic ovf_reg;
    logic ovf_next;
`endif

    // Global stall: every stage moves only when the output slot can drain.
    assign advance   = ~valid_reg[BK_STG_S3] | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_reg[BK_STG_S3];
    assign d         = d_reg;
    assign bout      = bout_reg;
`ifdef BK_SUB_OVF_EN
    assign ovf       = ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (advance) begin
            valid_reg[BK_STG_S1] <= in_valid;
            valid_reg[BK_STG_S2] <= valid_reg[BK_STG_S1];
            valid_reg[BK_STG_S3] <= valid_reg[BK_STG_S2];
        end
    end

    // S1: per-bit propagate/generate of a + ~b, carry-in is the inverted borrow.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_p_reg   <= a ^ ~b;
            s1_g_reg   <= a & ~b;
            s1_cin_reg <= ~bin;
`ifdef BK_SUB_OVF_EN
            s1_sa_reg  <= a[W-1];
            s1_sb_reg  <= b[W-1];
`endif
        end
    end

    // Folding cin into bit 0 turns every prefix generate into a true carry-out.
    assign g0_fold = {s1_g_reg[W-1:1], s1_g_reg[0] | (s1_p_reg[0] & s1_cin_reg)};

    genvar gl, gi;

    generate
        for (gl = 0; gl < LOG; gl++) begin : g_up
            logic [W-1:0] g_in, p_in, g_lvl, p_lvl;
            if (gl == 0) begin : g_base
                assign g_in = g0_fold;
                assign p_in = s1_p_reg;
            end else begin : g_link
                assign g_in = g_up[gl-1].g_lvl;
                assign p_in = g_up[gl-1].p_lvl;
            end
            for (gi = 0; gi < W; gi++) begin : g_bit
                if (((gi + 1) % (1 << (gl + 1))) == 0) begin : g_node
                    bk_pg_merge u_merge (
                        .g_hi (g_in[gi]),
                        .p_hi (p_in[gi]),
                        .g_lo (g_in[gi-(1<<gl)]),
                        .p_lo (p_in[gi-(1<<gl)]),
                        .g_out(g_lvl[gi]),
                        .p_out(p_lvl[gi])
                    );
                end else begin : g_pass
                    assign g_lvl[gi] = g_in[gi];
                    assign p_lvl[gi] = p_in[gi];
                end
            end
        end
    endgenerate

    assign up_g = g_up[LOG-1].g_lvl;
    assign up_p = g_up[LOG-1].p_lvl;

    // S2: up-sweep group tree plus the raw bit propagates needed for the sum.
    always_ff @(posedge clk) begin
        if (advance) begin
            s2_g_reg    <= up_g;
            s2_p_reg    <= up_p;
            s2_pbit_reg <= s1_p_reg;
            s2_cin_reg  <= s1_cin_reg;
`ifdef BK_SUB_OVF_EN
            s2_sa_reg   <= s1_sa_reg;
            s2_sb_reg   <= s1_sb_reg;
`endif
        end
    end

    // Down-sweep: fill in the prefixes the up-sweep left as partial groups.
    generate
        for (gl = 0; gl < LOG - 1; gl++) begin : g_dn
            logic [W-1:0] g_in, p_in, g_lvl, p_lvl;
            if (gl == LOG - 2) begin : g_top
                assign g_in = s2_g_reg;
                assign p_in = s2_p_reg;
            end else begin : g_link
                assign g_in = g_dn[gl+1].g_lvl;
                assign p_in = g_dn[gl+1].p_lvl;
            end
            for (gi = 0; gi < W; gi++) begin : g_bit
                if ((((gi + 1) % (1 << (gl + 1))) == (1 << gl)) && (gi >= (1 << (gl + 1)))) begin : g_node
                    bk_pg_merge u_merge (
                        .g_hi (g_in[gi]),
                        .p_hi (p_in[gi]),
                        .g_lo (g_in[gi-(1<<gl)]),
                        .p_lo (p_in[gi-(1<<gl)]),
                        .g_out(g_lvl[gi]),
                        .p_out(p_lvl[gi])
                    );
                end else begin : g_pass
                    assign g_lvl[gi] = g_in[gi];
                    assign p_lvl[gi] = p_in[gi];
                end
            end
        end
    endgenerate

    // Prefix propagates are dead once cin lives inside bit 0's generate.
    logic unused_prefix_p;
    assign unused_prefix_p = ^g_dn[0].p_lvl;

    assign carry_vec = {g_dn[0].g_lvl[W-2:0], s2_cin_reg};
    assign d_next    = s2_pbit_reg ^ carry_vec;
    assign bout_next = ~g_dn[0].g_lvl[W-1];
`ifdef BK_SUB_OVF_EN
    assign ovf_next  = (s2_sa_reg ^ s2_sb_reg) & (d_next[W-1] ^ s2_sa_reg);
`endif

    // S3: result register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg    <= '0;
            bout_reg <= 1'b0;
`ifdef BK_SUB_OVF_EN
            ovf_reg  <= 1'b0;
`endif
        end else if (advance) begin
            d_reg    <= d_next;
            bout_reg <= bout_next;
`ifdef BK_SUB_OVF_EN
            ovf_reg  <= ovf_next;
`endif
        end
    end

endmodule

// File: doc/bk_sub32_pipe.md
BK_SUB32_PIPE -- requirements
Module: bk_sub32_pipe

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand width; legal values are 8, 16, 32 and 64 (power of two).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand beat valid.
REQ-005 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-006 SHALL have port a  input  W  minuend.
REQ-007 SHALL have port b  input  W  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port d  output  W  difference, a - b - bin mod 2^W.
REQ-012 SHALL have port bout  output  1  borrow-out; 1 when a < b + bin, unsigned.
REQ-013 SHALL have port ovf  output  1  signed overflow; present only with BK_SUB_OVF_EN.

Function
REQ-014 SHALL compute d as a + ~b + ~bin through a Brent-Kung parallel-prefix carry network, with bout = ~carry_out.
REQ-015 SHALL use 3 register stages: S1 holds per-bit p/g, cin and the sign bits; S2 holds the up-sweep group g/p tree; S3 holds d, bout and ovf.
REQ-016 SHALL present a result on out_valid exactly 3 cycles after the accepting edge when out_ready stays high.
REQ-017 SHALL define advance = ~s3_valid | out_ready, and in_ready SHALL equal advance.
REQ-018 SHALL accept a beat only on in_valid & in_ready.
REQ-019 SHALL move all stages together when advance=1 and hold all stages when advance=0 (global stall, bubbles not collapsed).
REQ-020 SHALL sustain throughput of 1 result per cycle with out_ready held high.
REQ-021 SHALL preserve result order; no beat is dropped or duplicated.
REQ-022 SHALL keep d, bout and ovf stable while out_valid=1 and out_ready=0.
REQ-023 SHALL let each stage's valid follow the previous stage on advance; S1 valid loads in_valid & in_ready.
REQ-024 SHALL treat the boundary cases as ordinary arithmetic: a=b with bin=0 gives d=0, bout=0; a=0, b=0, bin=1 gives d=all-ones, bout=1.

Reset
REQ-025 SHALL clear all stage valid bits when rst=1 on a clock edge, so out_valid=0 from the next cycle.
REQ-026 SHALL set d=0, bout=0 and ovf=0 on reset.
REQ-027 SHALL discard any in-flight beats on a reset asserted mid-operation, with no partial output.
REQ-028 SHALL drive in_ready=1 during and after reset, because advance=1 when S3 is empty.

Configuration
REQ-029 SHALL, with BK_SUB_OVF_EN defined, add port ovf = (a[W-1]^b[W-1]) & (d[W-1]^a[W-1]), registered in lockstep with d.
REQ-030 SHALL, without BK_SUB_OVF_EN, omit port ovf and the sign-bit pipeline registers, with all other behaviour identical.

Structure
REQ-031 SHALL take its defaults from package bk_sub_pkg: BK_W_DEFAULT=32, BK_LATENCY=3 and the pipeline stage-index constants.
REQ-032 SHALL instantiate sub-module bk_pg_merge for the prefix cell, with g_out = g_hi | (p_hi & g_lo) and p_out = p_hi & p_lo, at every tree node.

Verification
REQ-033 SHALL be tested with a=5, b=3, bin=0, out_ready=1 -> d=2, bout=0, out_valid exactly 3 cycles after acceptance.
REQ-034 SHALL be tested with a=0, b=1, bin=0 -> d=0xFFFFFFFF, bout=1.
REQ-035 SHALL be tested with a=0x80000000, b=1, bin=0 and BK_SUB_OVF_EN set -> d=0x7FFFFFFF, ovf=1, bout=0.
REQ-036 SHALL be tested with 8 back-to-back beats and out_ready=0 for 4 cycles mid-stream -> in_ready low while stalled, all 8 results in order, outputs stable while stalled.
REQ-037 SHALL be tested with rst pulsed while 3 beats are in flight -> out_valid=0 the next cycle, no stale result after reset.
REQ-038 SHALL be tested with a=b=0xFFFFFFFF, bin=1 -> d=0xFFFFFFFF, bout=1.
